// File: rtl/soc_system_button_pio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : soc_system_button_pio
//  Function : Avalon-MM slave input PIO for push buttons and switches.
//             The raw lines pass through a 2-flop synchronizer and then a
//             per-bit debounce filter. The debounced level, an IRQ mask and
//             an edge-capture register are visible over the bus. One
//             level-sensitive interrupt line is driven to the HPS.
//  Revision : 1.0  initial release
// ============================================================================
module soc_system_button_pio #(
  parameter int WIDTH           = 4,      // number of input lines, 1..32
  parameter int DEBOUNCE_CYCLES = 50000,  // stable cycles before a change is accepted, 0 = bypass
  parameter int EDGE_TYPE       = 1       // 0 = rising, 1 = falling, 2 = any
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_RSVD  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  // Debounce counter counts 0..DEBOUNCE_CYCLES-1; never narrower than 1 bit.
  localparam int CNT_W_RAW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'((DEBOUNCE_CYCLES > 0) ? (DEBOUNCE_CYCLES - 1) : 0);

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] update;       // one-cycle pulse: stable takes sync2 this edge
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_evt;     // edges selected by EDGE_TYPE

  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] irq_mask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             irq_q;

  logic             bus_wr;
  logic             unused_wdata;

  assign bus_wr = chipselect & ~write_n;

  // Upper write-data bits have no storage behind them.
  assign unused_wdata = ^writedata;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer on the asynchronous pins
  // --------------------------------------------------------------------------
  // Bring the raw lines into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce filter
  // --------------------------------------------------------------------------
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // Filter disabled: stable tracks the synchronizer output directly.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable_q <= '0;
        end else begin
          stable_q <= sync2_q;
        end
      end

      assign update = sync2_q ^ stable_q;
    end else begin : g_filter
      logic [CNT_W-1:0] cnt_q [WIDTH];

      // A differing level must persist for DEBOUNCE_CYCLES cycles; any
      // reversion restarts the count from zero.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable_q <= '0;
          for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
              cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              stable_q[i] <= sync2_q[i];
              cnt_q[i]    <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
        end
      end

      // The update pulse coincides with the edge on which stable changes.
      always_comb begin
        update = '0;
        for (int i = 0; i < WIDTH; i++) begin
          update[i] = (sync2_q[i] != stable_q[i]) && (cnt_q[i] == CNT_MAX);
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Edge selection
  // --------------------------------------------------------------------------
  assign rise = update & sync2_q;
  assign fall = update & ~sync2_q;

  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign edge_evt = rise;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign edge_evt = fall;
    end else begin : g_edge_any
      assign edge_evt = rise | fall;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Register next-state logic
  // --------------------------------------------------------------------------
  // Mask write and write-1-to-clear of capture; a new edge wins over a clear.
  always_comb begin
    irq_mask_d = irq_mask_q;
    edgecap_d  = edgecap_q;
    if (bus_wr && (address == ADDR_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (bus_wr && (address == ADDR_EDGE)) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_evt;
  end

  // Read mux; unused upper bits are zero-filled.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d = 32'(stable_q);
      ADDR_RSVD: readdata_d = '0;
      ADDR_MASK: readdata_d = 32'(irq_mask_q);
      ADDR_EDGE: readdata_d = 32'(edgecap_q);
      default:   readdata_d = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Bus-visible registers
  // --------------------------------------------------------------------------
  // Mask, capture and read data update every cycle; reads have no side effects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  // Interrupt is formed only from registered state, so it lags the
  // register that caused it by one cycle and has no path from the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(edgecap_q & irq_mask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: doc/soc_system_button_pio.md
Name: soc_system_button_pio

Overview:
- Avalon-MM slave input PIO. It is the read-side counterpart of the LED output PIO in soc_system.
- Samples external push-button/switch lines through a 2-flop synchronizer, then a per-bit debounce filter.
- Exposes the debounced level, a per-bit interrupt mask and an edge-capture register to the HPS over the lightweight bridge.
- Drives one level-sensitive IRQ line.

Parameters:
- WIDTH, 4: number of input lines, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable clk cycles needed before a level change is accepted. 0 bypasses the filter.
- EDGE_TYPE, 1: edge that sets capture bits. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt to HPS.

Behaviour:
- Reset: all registers clear asynchronously when reset_n is low. This covers sync1, sync2, stable, debounce counters, irq_mask, edgecapture and readdata, all reset to 0.
  - Outputs after reset: irq=0, readdata=0.
  - Because stable resets to 0, an input held high through reset is accepted as a 0->1 change once debounce completes. That change sets capture if EDGE_TYPE is 0 or 2.
- Synchronizer: sync1<=in_port; sync2<=sync1. A change on in_port is visible at sync2 two clocks later.
- Debounce, per bit, with a counter of width clog2(DEBOUNCE_CYCLES) (minimum 1):
  - If sync2==stable, counter<=0.
  - Else if counter==DEBOUNCE_CYCLES-1, stable<=sync2, counter<=0, and an update event fires.
  - Else counter<=counter+1.
  - Net effect: stable follows sync2 exactly DEBOUNCE_CYCLES cycles after sync2 first differs, provided there is no reversion.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the counter and produces no update.
  - DEBOUNCE_CYCLES=0: stable<=sync2 every cycle; an update event fires whenever the two differ.
- Edge detect, per bit, qualified by the update event:
  - rise = update & sync2.
  - fall = update & ~sync2.
  - edge = rise, fall, or rise|fall according to EDGE_TYPE.
- Register map. Writes require chipselect=1 and write_n=0.
  - 0 DATA: read = stable zero-extended; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQ_MASK: read/write, writedata[WIDTH-1:0].
  - 3 EDGECAPTURE: read = edgecapture. Write is write-1-to-clear: edgecapture <= (edgecapture & ~writedata[WIDTH-1:0]) | edge.
- Edge capture:
  - A bit sets on the same clk edge that stable updates.
  - A bit stays set until cleared by software.
  - Set has priority over clear when both happen in the same cycle.
  - Captures occur regardless of mask.
- irq = |(edgecapture & irq_mask), driven from registers with no combinational path from the bus. It follows mask writes and clears one cycle after the write edge.
- Read:
  - readdata is registered every clk, independent of chipselect, from the current address mux.
  - Read latency is 1 cycle, 0 wait states.
  - Bits 31:WIDTH always read 0.
  - A read does not clear edgecapture.
- Reset asserted mid-debounce: the counter clears and no event is generated. After release, the filter restarts against stable=0.

Test Plan:
- Bench configuration for all cases: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1.
- Reset: with in_port=4'hF, release reset.
  - Read addr0 -> readdata=0 before debounce, then 0xF after 2+4 cycles.
  - edgecapture=0, since no falling edge occurred; irq=0.
- Falling edge with IRQ: write addr2=0x1, drive bit0 1->0 held 10 cycles.
  - Exactly 6 cycles after the change (2 sync + 4 debounce), stable[0]=0 and edgecapture=0x1.
  - irq=1 the following cycle.
  - Write addr3=0x1 -> edgecapture=0, irq=0 after the next edge.
- Glitch rejection: drive bit1 low for 3 cycles, then high.
  - stable stays 0xF, edgecapture unchanged, irq unchanged.
- Masked capture: with mask=0, drive bit2 falling.
  - edgecapture=0x4, irq=0.
  - Then write mask=0x4 -> irq=1 one cycle later.
- Simultaneous set/clear: time a write addr3=0x8 to land on the same edge as a bit3 falling-edge update.
  - edgecapture[3]=1 (set wins).
- Read map: write addr0=0xFFFFFFFF -> addr0 still reads the pin level.
  - addr1 reads 0.
  - Write addr2=0xFFFFFFF3 -> addr2 reads 0x3.
